stop_watch_counter: RTL and testbench
=====================================

// Module: stop_watch_counter
// PURPOSE
//  Stopwatch timebase and MM:SS counter feeding the mode FSM's stopwatch inputs
//  (stop_watch_minutes/seconds/ack_flag). Derives a 1 Hz tick from clk and provides
//  start/stop and lap/clear control. Edges are honoured only while the FSM grants
//  stop_watch_en. Ack tells the FSM it may leave stopwatch mode.
// PARAMETERS
//  TICK_DIV  50_000_000  clk cycles per counted second (>=2)
//  MAX_MIN   59          minute value after which count wraps to 00:00
// PORTS
//  clk                 in   1  system clock, all state on posedge
//  rst                 in   1  asynchronous, active-low reset
//  stop_watch_en       in   1  from FSM; 1 = stopwatch mode displayed, buttons live
//  start_stop_btn      in   1  debounced level; rising edge = start/stop
//  lap_clear_btn       in   1  debounced level; rising edge = lap / clear
//  stop_watch_minutes  out  6  displayed minutes 0..MAX_MIN (binary)
//  stop_watch_seconds  out  6  displayed seconds 0..59 (binary)
//  stop_watch_ack_flag out  1  1 when state is IDLE or PAUSE
//  running             out  1  1 when state is RUN or LAP
//  lap_active          out  1  1 when state is LAP (display frozen)
// BEHAVIOUR
//  Reset: state IDLE, live count 00:00, lap latch 00:00, prescaler 0, all outputs 0
//   except stop_watch_ack_flag = 1. btn_q registers reset to 1, so a button held
//   through reset gives no edge.
//  Edge detect: edge = btn & ~btn_q. btn_q updates every cycle regardless of enable.
//   Edges are acted on only when stop_watch_en = 1. If both edges occur in one cycle,
//   start_stop wins and lap_clear is dropped.
//  States and transitions (taken on the clock after the edge cycle):
//   IDLE  --ss-->  RUN    prescaler cleared to 0; lap edge ignored
//   RUN   --ss-->  PAUSE  ; --lap--> LAP: latch live count into lap latch
//   LAP   --ss-->  PAUSE  display returns to live count; --lap--> RUN: display live
//   PAUSE --ss-->  RUN    prescaler resumes from held value
//   PAUSE --lap--> IDLE   live count, lap latch and prescaler cleared to 0
//  Prescaler: counts only in RUN and LAP. At TICK_DIV-1 it wraps to 0 and raises a
//   one-cycle tick. In IDLE and PAUSE it holds its value.
//  Count on tick: sec+1. At 59, sec=0 and min+1. At MAX_MIN:59 the count wraps to
//   00:00 and keeps running. Update is visible on the cycle after the tick.
//  A tick in the same cycle as a RUN/LAP->PAUSE edge is discarded. A tick in the same
//   cycle as a RUN<->LAP edge is applied.
//  Counting continues in RUN and LAP while stop_watch_en = 0 (background running).
//   Outputs remain valid in that case.
//  Display: stop_watch_minutes/seconds = lap latch in LAP, live count otherwise.
//   All outputs are registered or decoded from registered state only.
//  Latency: button rise to output change = 1 clk. Tick to count change = 1 clk.
//  rst asserted mid-run returns to the reset state immediately (asynchronous).
// STRUCTURE
//  Shared package clock_pkg holds:
//   - sw_state_t enum: IDLE=2'b00, RUN=2'b01, LAP=2'b11, PAUSE=2'b10
//   - SEC_MAX = 6'd59
//   - MIN_W = 6, SEC_W = 6 (shared with the FSM and set_time blocks)
//  One sub-module, sec_tick_gen (TICK_DIV): prescaler with inputs run_en and clr,
//   output tick. The state machine, MM:SS counter, lap latch and output mux stay
//   in this module.
// TESTING (bench uses TICK_DIV=4, MAX_MIN=59)
//  1. Hold rst low, then release. Expect 00:00, ack=1, running=0.
//     Hold start_stop_btn=1 through reset. Expect no transition.
//  2. en=1, ss pulse, then 240 clk. Expect running=1, ack=0, display 01:00.
//     Expect the first second at cycle 4 after RUN is entered.
//  3. Preload 59:58 and run 8 clk. Expect 59:59, then 00:00 with running still 1.
//  4. At 00:05 in RUN, lap pulse, then 12 clk. Expect display held at 00:05,
//     lap_active=1. Second lap pulse -> display shows 00:08.
//  5. ss and lap rising in the same cycle in RUN. Expect PAUSE, lap ignored, ack=1.
//     Then lap pulse -> IDLE, 00:00.
//  6. en=0 in RUN with ss pulses. Expect ignored, count still advancing.
//     Assert rst mid-count -> all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock/stopwatch blocks.
//   sw_state_t : stopwatch control states (encoding shared with the mode FSM)
//   SEC_MAX    : last second value before the minute rolls
//   MIN_W/SEC_W: widths of the minutes/seconds buses
//   is_counting: 1 for the states in which the timebase advances
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b11,
    PAUSE = 2'b10
  } sw_state_t;

  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  function automatic logic is_counting(input sw_state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stop_watch_counter_sec_tick_gen.sv
// Seconds prescaler for the stopwatch.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-low reset
//   run_en in  1 = advance the prescaler this cycle, 0 = hold its value
//   clr    in  synchronous clear of the prescaler to 0
//   tick   out one-cycle pulse on the cycle the prescaler sits at TICK_DIV-1
//              while running (the count wraps to 0 on the same edge)
module sec_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run_en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_r;

  // Prescaler register: clear has priority, otherwise count and wrap while enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (run_en) begin
      if (count_r == TERM) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + CNT_W'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign tick = run_en && (count_r == TERM);

endmodule

// File: rtl/stop_watch_counter.sv
// Stopwatch timebase and MM:SS counter for the mode FSM.
// Ports:
//   clk                 in  system clock
//   rst                 in  asynchronous active-low reset
//   stop_watch_en       in  1 = stopwatch mode shown, buttons honoured
//   start_stop_btn      in  debounced level, rising edge = start/stop
//   lap_clear_btn       in  debounced level, rising edge = lap/clear
//   stop_watch_minutes  out displayed minutes (lap latch in LAP, live otherwise)
//   stop_watch_seconds  out displayed seconds
//   stop_watch_ack_flag out 1 in IDLE or PAUSE (FSM may leave stopwatch mode)
//   running             out 1 in RUN or LAP
//   lap_active          out 1 in LAP (display frozen)
module stop_watch_counter
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int MAX_MIN  = 59
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stop_watch_en,
  input  logic             start_stop_btn,
  input  logic             lap_clear_btn,
  output logic [MIN_W-1:0] stop_watch_minutes,
  output logic [SEC_W-1:0] stop_watch_seconds,
  output logic             stop_watch_ack_flag,
  output logic             running,
  output logic             lap_active
);

  localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MAX_MIN);

  sw_state_t        state_r;
  sw_state_t        state_s;
  logic             ss_q_r;
  logic             lap_q_r;
  logic             ss_edge_s;
  logic             lap_edge_s;
  logic             clr_all_s;
  logic             latch_s;
  logic             presc_clr_s;
  logic             drop_tick_s;
  logic             tick_s;
  logic             count_en_s;
  logic [MIN_W-1:0] min_r;
  logic [SEC_W-1:0] sec_r;
  logic [MIN_W-1:0] lap_min_r;
  logic [SEC_W-1:0] lap_sec_r;

  // Button history registers; reset high so a button held through reset gives no edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_q_r  <= 1'b1;
      lap_q_r <= 1'b1;
    end else begin
      ss_q_r  <= start_stop_btn;
      lap_q_r <= lap_clear_btn;
    end
  end

  // start/stop beats lap/clear when both rise together.
  assign ss_edge_s  = stop_watch_en && start_stop_btn && !ss_q_r;
  assign lap_edge_s = stop_watch_en && lap_clear_btn && !lap_q_r && !ss_edge_s;

  sec_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .run_en(is_counting(state_r)),
    .clr   (presc_clr_s),
    .tick  (tick_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and per-transition side effects.
  always_comb begin
    state_s     = state_r;
    clr_all_s   = 1'b0;
    latch_s     = 1'b0;
    presc_clr_s = 1'b0;
    drop_tick_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (ss_edge_s) begin
          state_s     = RUN;
          presc_clr_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (ss_edge_s) begin
          state_s     = PAUSE;
          drop_tick_s = 1'b1;
        end else if (lap_edge_s) begin
          state_s = LAP;
          latch_s = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      LAP: begin
        if (ss_edge_s) begin
          state_s     = PAUSE;
          drop_tick_s = 1'b1;
        end else if (lap_edge_s) begin
          state_s = RUN;
        end else begin
          state_s = LAP;
        end
      end
      PAUSE: begin
        if (ss_edge_s) begin
          state_s = RUN;
        end else if (lap_edge_s) begin
          state_s     = IDLE;
          clr_all_s   = 1'b1;
          presc_clr_s = 1'b1;
        end else begin
          state_s = PAUSE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // A tick coinciding with a stop request is discarded so the paused value is exact.
  assign count_en_s = tick_s && !drop_tick_s;

  // Live MM:SS counter, wraps from MAX_MIN:59 to 00:00 and keeps going.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_r <= '0;
      sec_r <= '0;
    end else if (clr_all_s) begin
      min_r <= '0;
      sec_r <= '0;
    end else if (count_en_s) begin
      if (sec_r == SEC_MAX) begin
        sec_r <= '0;
        if (min_r == MIN_LAST) begin
          min_r <= '0;
        end else begin
          min_r <= min_r + MIN_W'(1);
        end
      end else begin
        sec_r <= sec_r + SEC_W'(1);
      end
    end else begin
      min_r <= min_r;
      sec_r <= sec_r;
    end
  end

  // Lap latch: captures the pre-tick live count on entry to LAP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_min_r <= '0;
      lap_sec_r <= '0;
    end else if (clr_all_s) begin
      lap_min_r <= '0;
      lap_sec_r <= '0;
    end else if (latch_s) begin
      lap_min_r <= min_r;
      lap_sec_r <= sec_r;
    end else begin
      lap_min_r <= lap_min_r;
      lap_sec_r <= lap_sec_r;
    end
  end

  assign lap_active          = (state_r == LAP);
  assign running             = is_counting(state_r);
  assign stop_watch_ack_flag = (state_r == IDLE) || (state_r == PAUSE);
  assign stop_watch_minutes  = lap_active ? lap_min_r : min_r;
  assign stop_watch_seconds  = lap_active ? lap_sec_r : sec_r;

endmodule

// File: tb/tb_stop_watch_counter.sv
// Self-checking bench for stop_watch_counter (TICK_DIV=4, MAX_MIN=59).
// Reference model: elapsed time kept as total seconds, prescaler as a phase
// number, mode as a small integer; the expected display is derived with / and %.
module tb_stop_watch_counter;

  localparam int TICK_DIV = 4;
  localparam int MAX_MIN  = 59;
  localparam int WRAP     = (MAX_MIN + 1) * 60;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_LAP   = 2;
  localparam int M_PAUSE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stop_watch_en = 1'b0;
  logic       start_stop_btn = 1'b0;
  logic       lap_clear_btn = 1'b0;
  logic [5:0] stop_watch_minutes;
  logic [5:0] stop_watch_seconds;
  logic       stop_watch_ack_flag;
  logic       running;
  logic       lap_active;

  int vectors = 0;
  int miscompares = 0;

  int m_mode;
  int m_phase;
  int m_total;
  int m_lap;
  bit m_ss_prev;
  bit m_lap_prev;

  stop_watch_counter #(
    .TICK_DIV(TICK_DIV),
    .MAX_MIN (MAX_MIN)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .stop_watch_en      (stop_watch_en),
    .start_stop_btn     (start_stop_btn),
    .lap_clear_btn      (lap_clear_btn),
    .stop_watch_minutes (stop_watch_minutes),
    .stop_watch_seconds (stop_watch_seconds),
    .stop_watch_ack_flag(stop_watch_ack_flag),
    .running            (running),
    .lap_active         (lap_active)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode     = M_IDLE;
    m_phase    = 0;
    m_total    = 0;
    m_lap      = 0;
    m_ss_prev  = 1'b1;
    m_lap_prev = 1'b1;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_clock(input bit ss, input bit lap, input bit en);
    bit ss_rise, lap_rise, tk, drop;
    ss_rise    = en && ss && !m_ss_prev;
    lap_rise   = en && lap && !m_lap_prev && !ss_rise;
    m_ss_prev  = ss;
    m_lap_prev = lap;
    tk   = 1'b0;
    drop = 1'b0;
    if (m_mode == M_RUN || m_mode == M_LAP) begin
      tk      = (m_phase == TICK_DIV - 1);
      m_phase = (m_phase + 1) % TICK_DIV;
    end
    case (m_mode)
      M_IDLE: if (ss_rise) begin m_mode = M_RUN; m_phase = 0; end
      M_RUN: begin
        if (ss_rise) begin m_mode = M_PAUSE; drop = 1'b1; end
        else if (lap_rise) begin m_mode = M_LAP; m_lap = m_total; end
      end
      M_LAP: begin
        if (ss_rise) begin m_mode = M_PAUSE; drop = 1'b1; end
        else if (lap_rise) m_mode = M_RUN;
      end
      default: begin
        if (ss_rise) m_mode = M_RUN;
        else if (lap_rise) begin
          m_mode = M_IDLE; m_total = 0; m_lap = 0; m_phase = 0;
        end
      end
    endcase
    if (tk && !drop) m_total = (m_total + 1) % WRAP;
  endtask

  task automatic check_outputs();
    int disp;
    disp = (m_mode == M_LAP) ? m_lap : m_total;
    check_value("minutes", stop_watch_minutes, disp / 60);
    check_value("seconds", stop_watch_seconds, disp % 60);
    check_value("ack", stop_watch_ack_flag, (m_mode == M_IDLE || m_mode == M_PAUSE) ? 1 : 0);
    check_value("running", running, (m_mode == M_RUN || m_mode == M_LAP) ? 1 : 0);
    check_value("lap_active", lap_active, (m_mode == M_LAP) ? 1 : 0);
  endtask

  // Drive inputs on the falling edge, model the rising edge, check 1 time unit later.
  task automatic step(input bit ss, input bit lap, input bit en);
    @(negedge clk);
    start_stop_btn = ss;
    lap_clear_btn  = lap;
    stop_watch_en  = en;
    @(posedge clk);
    model_clock(ss, lap, en);
    #1;
    check_outputs();
  endtask

  initial begin
    // 1. reset with start_stop held high through release
    model_reset();
    stop_watch_en  = 1'b1;
    start_stop_btn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;
    repeat (3) step(1'b1, 1'b0, 1'b1);
    check_value("t1_held_no_run", running, 0);
    check_value("t1_ack", stop_watch_ack_flag, 1);
    step(1'b0, 1'b0, 1'b1);

    // 2. start, first second after 4 cycles, 01:00 after 240 cycles
    step(1'b1, 1'b0, 1'b1);
    check_value("t2_running", running, 1);
    check_value("t2_ack", stop_watch_ack_flag, 0);
    for (int i = 0; i < 240; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (i == 2) check_value("t2_sec_before_tick", stop_watch_seconds, 0);
      if (i == 3) check_value("t2_first_second", stop_watch_seconds, 1);
    end
    check_value("t2_min", stop_watch_minutes, 1);
    check_value("t2_sec", stop_watch_seconds, 0);

    // 3. run up to 59:58, then wrap through 59:59 to 00:00
    for (int n = 0; n < 20000 && m_total != WRAP - 2; n++) step(1'b0, 1'b0, 1'b1);
    check_value("t3_min_5958", stop_watch_minutes, 59);
    check_value("t3_sec_5958", stop_watch_seconds, 58);
    repeat (4) step(1'b0, 1'b0, 1'b1);
    check_value("t3_min_5959", stop_watch_minutes, 59);
    check_value("t3_sec_5959", stop_watch_seconds, 59);
    repeat (4) step(1'b0, 1'b0, 1'b1);
    check_value("t3_min_wrap", stop_watch_minutes, 0);
    check_value("t3_sec_wrap", stop_watch_seconds, 0);
    check_value("t3_running", running, 1);

    // 4. lap at 00:05, display frozen, second lap shows live 00:08
    for (int n = 0; n < 100 && m_total != 5; n++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (12) step(1'b0, 1'b0, 1'b1);
    check_value("t4_frozen_sec", stop_watch_seconds, 5);
    check_value("t4_lap_active", lap_active, 1);
    step(1'b0, 1'b1, 1'b1);
    check_value("t4_live_sec", stop_watch_seconds, 8);
    check_value("t4_lap_off", lap_active, 0);
    step(1'b0, 1'b0, 1'b1);

    // 5. simultaneous edges -> PAUSE; then lap -> IDLE cleared
    step(1'b1, 1'b1, 1'b1);
    check_value("t5_pause_ack", stop_watch_ack_flag, 1);
    check_value("t5_pause_run", running, 0);
    check_value("t5_pause_lap", lap_active, 0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check_value("t5_clr_min", stop_watch_minutes, 0);
    check_value("t5_clr_sec", stop_watch_seconds, 0);
    check_value("t5_idle_ack", stop_watch_ack_flag, 1);
    step(1'b0, 1'b0, 1'b1);

    // 6. background running with buttons ignored, then async reset mid-count
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    check_value("t6_bg_running", running, 1);
    check_value("t6_bg_sec", stop_watch_seconds, 10);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_value("t6_rst_sec", stop_watch_seconds, 0);
    check_value("t6_rst_min", stop_watch_minutes, 0);
    check_value("t6_rst_run", running, 0);
    check_value("t6_rst_ack", stop_watch_ack_flag, 1);
    check_value("t6_rst_lap", lap_active, 0);
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 7) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
